// File: rtl/fp_divide_seq_pkg.sv
// rtl/fp_divide_seq_pkg.sv - shared state encoding, flag positions and exponent bias helper
package fp_divide_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int FLAG_W         = 4;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_divide_seq_step.sv
// rtl/fp_divide_seq_step.sv - one combinational radix-2 restoring division step
module fp_div_step #(
   parameter int WIDTH = 25
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH-1:0] diff;

   // rem < 2*divisor is invariant, so the left shift never loses a set bit
   always_comb begin
      q_bit    = (rem >= divisor);
      diff     = q_bit ? (rem - divisor) : rem;
      rem_next = diff << 1;
   end

endmodule

// File: rtl/fp_divide_seq.sv
// rtl/fp_divide_seq.sv - multi-cycle IEEE-754 divider with handshakes, RNE rounding and flags
module fp_divide_seq
   import fp_divide_seq_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [FLAG_W-1:0]        flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 3;
   localparam int RW = MAN_W + 2;
   localparam int CW = $clog2(N + 1);
   localparam int EW = EXP_W + 2;

   localparam logic signed [EW-1:0] BIAS  = EW'(exp_bias(EXP_W));
   localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ONE   = EW'(1);
   localparam logic [CW-1:0]        LAST  = CW'(N - 1);
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [W-1:0]         QNAN  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   state_t state, state_nx;

   logic                 sa, sb, sq;
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     ma, mb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   logic                 spec_hit;
   logic [W-1:0]         spec_res;
   logic [FLAG_W-1:0]    spec_flags;

   logic [RW-1:0]        rem, div, rem_nx;
   logic                 q_bit;
   logic [N-1:0]         q;
   logic signed [EW-1:0] e, e_load;
   logic [CW-1:0]        cnt;
   logic                 sign_r;

   logic [N-2:0]         q_frac;
   logic signed [EW-1:0] e_norm, e_fin;
   logic [MAN_W:0]       frac_sum;
   logic                 round_up;
   logic [W-1:0]         rnd_res;
   logic [FLAG_W-1:0]    rnd_flags;

   assign {sa, ea, ma} = a;
   assign {sb, eb, mb} = b;
   assign sq     = sa ^ sb;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (ma == '0);
   assign b_inf  = (eb == EXP_ONES) && (mb == '0);
   assign a_nan  = (ea == EXP_ONES) && (ma != '0);
   assign b_nan  = (eb == EXP_ONES) && (mb != '0);
   assign e_load = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

   // Subnormal operands fall into the zero classes (flush-to-zero)
   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (a_nan || b_nan) begin
         spec_res = QNAN;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res = QNAN;
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
         spec_res = {sq, EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_zero) begin
         spec_res = {sq, EXP_ONES, {MAN_W{1'b0}}};
         spec_flags[FLAG_DIV_ZERO] = 1'b1;
      end else if (b_inf || a_zero) begin
         spec_res = {sq, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   fp_div_step #(.WIDTH(RW)) u_step (
      .rem      (rem),
      .divisor  (div),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   // Quotient is in [0.5, 2): normalise, then round on guard/round/sticky
   always_comb begin
      q_frac    = q[N-1] ? q[N-2:0] : {q[N-3:0], 1'b0};
      e_norm    = q[N-1] ? e : e - ONE;
      round_up  = q_frac[1] & (q_frac[0] | (|rem) | q_frac[2]);
      frac_sum  = {1'b0, q_frac[N-2:2]} + {{MAN_W{1'b0}}, round_up};
      e_fin     = frac_sum[MAN_W] ? e_norm + ONE : e_norm;
      rnd_flags = '0;
      if (e_fin >= E_MAX) begin
         rnd_res = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
         rnd_flags[FLAG_OVERFLOW] = 1'b1;
      end else if (e_fin[EW-1] || (e_fin == '0)) begin
         rnd_res = {sign_r, {(W-1){1'b0}}};
         rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      end else begin
         rnd_res = {sign_r, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (in_valid) state_nx = spec_hit ? S_DONE : S_ITER;
         S_ITER:  if (cnt == LAST) state_nx = S_ROUND;
         S_ROUND: state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         div    <= '0;
         q      <= '0;
         e      <= '0;
         cnt    <= '0;
         sign_r <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               sign_r <= sq;
               if (spec_hit) begin
                  result <= spec_res;
                  flags  <= spec_flags;
               end else begin
                  rem <= {2'b01, ma};
                  div <= {2'b01, mb};
                  e   <= e_load;
                  q   <= '0;
                  cnt <= '0;
               end
            end
            S_ITER: begin
               rem <= rem_nx;
               q   <= {q[N-2:0], q_bit};
               cnt <= cnt + CW'(1);
            end
            S_ROUND: begin
               result <= rnd_res;
               flags  <= rnd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divide_seq.sv
// tb/tb_fp_divide_seq.sv - self-checking bench for fp_divide_seq against an integer-division model
module tb_fp_divide_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [3:0]  flags;

   logic        h_in_valid = 1'b0;
   logic        h_in_ready;
   logic [15:0] h_a = '0;
   logic [15:0] h_b = '0;
   logic        h_out_valid;
   logic        h_out_ready = 1'b1;
   logic [15:0] h_result;
   logic [3:0]  h_flags;

   int checks = 0;
   int failures = 0;

   logic [31:0] dir_a [8] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                              32'h00000000, 32'h7FC00001, 32'h7F000000, 32'h00800000};
   logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                              32'h00000000, 32'h3F800000, 32'h00800000, 32'h40000000};
   logic [31:0] dir_r [8] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000,
                              32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
   logic [3:0]  dir_f [8] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h2, 4'h1};
   int          dir_l [8] = '{28, 28, 28, 1, 1, 1, 28, 28};

   always #5 clk = ~clk;

   fp_divide_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   fp_divide_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result), .flags(h_flags)
   );

   // Reference: exact integer quotient of the significands, then RNE on the bits beyond 24
   function automatic void model_div(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output logic [3:0] f,
                                     output bit special);
      int ex, ey, e;
      longint mx, my, num, q, rm, keep;
      bit sq, nx, ny, ix, iy, zx, zy, guard, rest;
      ex = int'(x[30:23]); ey = int'(y[30:23]);
      mx = longint'(x[22:0]); my = longint'(y[22:0]);
      sq = x[31] ^ y[31];
      nx = (ex == 255) && (mx != 0); ny = (ey == 255) && (my != 0);
      ix = (ex == 255) && (mx == 0); iy = (ey == 255) && (my == 0);
      zx = (ex == 0); zy = (ey == 0);
      f = 4'h0; special = 1'b1;
      if (nx || ny) r = 32'h7FC00000;
      else if ((zx && zy) || (ix && iy)) begin r = 32'h7FC00000; f = 4'h8; end
      else if (ix) r = {sq, 31'h7F800000};
      else if (zy) begin r = {sq, 31'h7F800000}; f = 4'h4; end
      else if (iy || zx) r = {sq, 31'h0};
      else begin
         special = 1'b0;
         mx = mx + (64'd1 << 23); my = my + (64'd1 << 23);
         e = ex - ey + 127;
         num = mx << 25;
         if (mx < my) begin num = num << 1; e = e - 1; end
         q = num / my; rm = num % my;
         keep = q >> 2;
         guard = q[1];
         rest = q[0] || (rm != 0);
         if (guard && (rest || keep[0])) keep = keep + 1;
         if (keep == (64'd1 << 24)) begin keep = 64'd1 << 23; e = e + 1; end
         if (e >= 255) begin r = {sq, 31'h7F800000}; f = 4'h2; end
         else if (e <= 0) begin r = {sq, 31'h0}; f = 4'h1; end
         else r = {sq, 8'(e), 23'(keep)};
      end
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      int k;
      v = $urandom;
      k = $urandom_range(0, 15);
      case (k)
         0: v[30:0] = '0;
         1: v[30:0] = 31'h7F800000;
         2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
         3: begin v[30:23] = 8'h00; v[0] = 1'b1; end
         4: v[30:23] = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
         default: v[30:23] = 8'($urandom_range(64, 190));
      endcase
      return v;
   endfunction

   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
      int wait_c;
      wait_c = 0;
      while (!in_ready && wait_c < 200) begin @(posedge clk); #1; wait_c++; end
      a = op_a; b = op_b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      if (!out_valid) lat = -1;
      r = result; f = flags;
      if (out_ready) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++;
      if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
      checks++;
      if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h want=0", flags); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] r;
      logic [3:0] f;
      int lat;
      for (int i = 0; i < 8; i++) begin
         run_op(dir_a[i], dir_b[i], r, f, lat);
         checks++;
         if (r !== dir_r[i]) begin failures++; $display("FAIL directed%0d_result got=%h want=%h", i, r, dir_r[i]); end
         checks++;
         if (f !== dir_f[i]) begin failures++; $display("FAIL directed%0d_flags got=%h want=%h", i, f, dir_f[i]); end
         checks++;
         if (lat != dir_l[i]) begin failures++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, dir_l[i]); end
      end
   endtask

   task automatic test_half();
      int lat;
      h_a = 16'h4200; h_b = 16'h3C00; h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++;
      if (h_result !== 16'h4200) begin failures++; $display("FAIL half_result got=%h want=4200", h_result); end
      checks++;
      if (h_flags !== 4'h0) begin failures++; $display("FAIL half_flags got=%h want=0", h_flags); end
      checks++;
      if (lat != 15) begin failures++; $display("FAIL half_latency got=%0d want=15", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_random(input int count);
      logic [31:0] x, y, r, mr;
      logic [3:0] f, mf;
      bit sp;
      int lat;
      for (int i = 0; i < count; i++) begin
         x = rand_operand();
         y = rand_operand();
         model_div(x, y, mr, mf, sp);
         run_op(x, y, r, f, lat);
         checks++;
         if (r !== mr || f !== mf) begin
            failures++;
            $display("FAIL random_op a=%h b=%h got=%h/%h want=%h/%h", x, y, r, f, mr, mf);
         end
         checks++;
         if (lat != (sp ? 1 : 28)) begin
            failures++;
            $display("FAIL random_latency a=%h b=%h got=%0d want=%0d", x, y, lat, sp ? 1 : 28);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x, y, r, mr;
      logic [3:0] f, mf;
      bit sp;
      int lat;
      for (int i = 0; i < 20; i++) begin
         x = rand_operand();
         y = rand_operand();
         model_div(x, y, mr, mf, sp);
         run_op(x, y, r, f, lat);
         checks++;
         if (r !== mr || f !== mf) begin
            failures++;
            $display("FAIL b2b_op a=%h b=%h got=%h/%h want=%h/%h", x, y, r, f, mr, mf);
         end
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_after got=%b%b want=10", in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      logic [3:0] f;
      int lat;
      out_ready = 1'b0;
      run_op(32'h40C00000, 32'h40000000, r, f, lat);
      checks++;
      if (r !== 32'h40400000 || lat != 28) begin
         failures++;
         $display("FAIL bp_first got=%h lat=%0d want=40400000 lat=28", r, lat);
      end
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000 || flags !== 4'h0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=v%b r%b %h %h want=v1 r0 40400000 0",
                     i, out_valid, in_ready, result, flags);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got=r%b v%b want=r1 v0", in_ready, out_valid);
      end
      run_op(32'h3F800000, 32'h40400000, r, f, lat);
      checks++;
      if (r !== 32'h3EAAAAAB || f !== 4'h0 || lat != 28) begin
         failures++;
         $display("FAIL bp_next got=%h/%h lat=%0d want=3EAAAAAB/0 lat=28", r, f, lat);
      end
   endtask

   task automatic test_reset_mid_iter();
      logic [31:0] r;
      logic [3:0] f;
      int lat, seen;
      a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_iter got=v%b r%b want=v0 r1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL rst_no_result got=%0d want=0", seen); end
      run_op(32'h40C00000, 32'h40000000, r, f, lat);
      checks++;
      if (r !== 32'h40400000 || f !== 4'h0 || lat != 28) begin
         failures++;
         $display("FAIL rst_after got=%h/%h lat=%0d want=40400000/0 lat=28", r, f, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_half();
      test_random(300);
      test_back_to_back();
      test_backpressure();
      test_reset_mid_iter();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
